pc_fetch_unit: RTL

//  Owns the program counter register and the instruction-fetch handshake of the multicycle CPU.

---
 rtl/pc_fetch_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch handshake for the multicycle core.
// Issues word fetches, holds the returned instruction, applies redirects.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic [31:0] ir_pc4,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    HALTED
  } state_t;

  state_t      st, st_n;
  logic [31:0] pc, pc_n;
  logic [31:0] addr_n;
  logic        req_n;
  logic        sq, sq_n;
  logic        v_n;
  logic [31:0] ir_n, irpc_n, irpc4_n;
  logic        acc;
  logic [31:0] tgt;
  logic [31:0] pc4;

  assign acc = imem_req & imem_ack;
  assign tgt = {redirect_pc[31:2], 2'b00};
  assign pc4 = pc + 32'd4;

  // Next-state, next-PC and output-register values.
  always_comb begin
    st_n    = st;
    pc_n    = pc;
    addr_n  = imem_addr;
    req_n   = imem_req;
    sq_n    = sq;
    v_n     = ir_valid;
    ir_n    = ir;
    irpc_n  = ir_pc;
    irpc4_n = ir_pc4;
    unique case (st)
      IDLE: begin
        st_n  = halt ? HALTED : FETCH;
        req_n = !halt;
      end
      FETCH: begin
        if (acc) begin
          sq_n = 1'b0;
          if (!sq && !redirect) begin
            ir_n    = imem_rdata;
            irpc_n  = pc;
            irpc4_n = pc4;
            pc_n    = pc4;
            v_n     = 1'b1;
            st_n    = HOLD;
            req_n   = 1'b0;
          end else begin
            // A squashed return leaves one idle bus cycle before re-request.
            req_n = !sq;
          end
        end else if (!imem_req) begin
          req_n = 1'b1;
        end else if (redirect) begin
          // The outstanding request cannot be withdrawn; drop its return.
          sq_n = 1'b1;
        end
      end
      HOLD: begin
        if (ir_ready || redirect) begin
          v_n   = 1'b0;
          st_n  = halt ? HALTED : FETCH;
          req_n = !halt;
        end
      end
      HALTED: begin
        if (!halt) begin
          st_n  = FETCH;
          req_n = 1'b1;
        end
      end
    endcase
    if (redirect)
      pc_n = tgt;
    // Address only moves when a new request is launched.
    if (req_n && (!imem_req || acc))
      addr_n = pc_n;
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st        <= IDLE;
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
      imem_req  <= 1'b0;
      sq        <= 1'b0;
      ir_valid  <= 1'b0;
      ir        <= 32'd0;
      ir_pc     <= 32'd0;
      ir_pc4    <= 32'd0;
    end else begin
      st        <= st_n;
      pc        <= pc_n;
      imem_addr <= addr_n;
      imem_req  <= req_n;
      sq        <= sq_n;
      ir_valid  <= v_n;
      ir        <= ir_n;
      ir_pc     <= irpc_n;
      ir_pc4    <= irpc4_n;
    end
  end

endmodule
